// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared widths and FSM state encoding for the data cache
package dcache_pkg;

  localparam int TAG_W   = 3;
  localparam int IDX_W   = 3;
  localparam int OFF_W   = 2;
  localparam int BLOCK_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    FETCH  = 2'd2,
    UPDATE = 2'd3
  } state_t;

endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - valid/dirty/tag/data storage for the direct-mapped cache
// Ports:
//   clk, rst                 clock and asynchronous active-high reset (clears valid/dirty)
//   idx                      line index for both the read port and the write port
//   line_valid/dirty/tag/data combinational read of line idx
//   byte_we, byte_off, byte_data  store one byte into line idx and mark it dirty
//   fill_we, fill_tag, fill_data  load a whole block, set valid, clear dirty
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NBLOCKS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_W-1:0]   idx,
  output logic               line_valid,
  output logic               line_dirty,
  output logic [TAG_W-1:0]   line_tag,
  output logic [BLOCK_W-1:0] line_data,
  input  logic               byte_we,
  input  logic [OFF_W-1:0]   byte_off,
  input  logic [7:0]         byte_data,
  input  logic               fill_we,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [BLOCK_W-1:0] fill_data
);

  logic [NBLOCKS-1:0] valid_q;
  logic [NBLOCKS-1:0] dirty_q;
  logic [TAG_W-1:0]   tag_q  [NBLOCKS];
  logic [BLOCK_W-1:0] data_q [NBLOCKS];

  assign line_valid = valid_q[idx];
  assign line_dirty = dirty_q[idx];
  assign line_tag   = tag_q[idx];
  assign line_data  = data_q[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (byte_we) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data contents need no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_data;
    end else if (byte_we) begin
      data_q[idx][{byte_off, 3'b000} +: 8] <= byte_data;
    end
  end

endmodule

// File: rtl/dcache.sv
// rtl/dcache.sv - direct-mapped write-back write-allocate data cache with CPU stall
// Ports:
//   CLOCK, RESET             clock and asynchronous active-high reset
//   READ, WRITE, ADDRESS     CPU request (held until BUSYWAIT low), byte address
//   WRITEDATA, READDATA      store byte in, load byte out
//   BUSYWAIT                 combinational stall to the CPU
//   MEM_READ, MEM_WRITE      block fetch / write-back requests
//   MEM_ADDRESS              block address {tag, index}
//   MEM_WRITEDATA            evicted block, MEM_READDATA fetched block
//   MEM_BUSYWAIT             memory busy
module dcache
  import dcache_pkg::*;
#(
  parameter int NBLOCKS = 8
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               READ,
  input  logic               WRITE,
  input  logic [7:0]         ADDRESS,
  input  logic [7:0]         WRITEDATA,
  output logic [7:0]         READDATA,
  output logic               BUSYWAIT,
  output logic               MEM_READ,
  output logic               MEM_WRITE,
  output logic [5:0]         MEM_ADDRESS,
  output logic [BLOCK_W-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0] MEM_READDATA,
  input  logic               MEM_BUSYWAIT
);

  state_t state, state_next;
  logic   seen_busy;

  logic [TAG_W-1:0]   tag_in;
  logic [IDX_W-1:0]   idx;
  logic [OFF_W-1:0]   off;
  logic               line_valid, line_dirty;
  logic [TAG_W-1:0]   line_tag;
  logic [BLOCK_W-1:0] line_data;
  logic               req, hit, idle_hit, rd_hit, byte_we, fill_we, mem_done;
  logic [7:0]         sel_byte, readdata_q;

  assign tag_in = ADDRESS[7:5];
  assign idx    = ADDRESS[4:2];
  assign off    = ADDRESS[1:0];

  dcache_array #(.NBLOCKS(NBLOCKS)) u_array (
    .clk        (CLOCK),
    .rst        (RESET),
    .idx        (idx),
    .line_valid (line_valid),
    .line_dirty (line_dirty),
    .line_tag   (line_tag),
    .line_data  (line_data),
    .byte_we    (byte_we),
    .byte_off   (off),
    .byte_data  (WRITEDATA),
    .fill_we    (fill_we),
    .fill_tag   (tag_in),
    .fill_data  (MEM_READDATA)
  );

  assign req      = READ | WRITE;
  assign hit      = line_valid && (line_tag == tag_in);
  assign idle_hit = (state == IDLE) && hit;
  assign BUSYWAIT = req && !idle_hit;

  // A simultaneous READ and WRITE is a store, so it must not disturb READDATA.
  assign rd_hit   = READ && !WRITE && idle_hit;
  assign byte_we  = WRITE && idle_hit;
  assign fill_we  = (state == UPDATE);
  assign sel_byte = line_data[{off, 3'b000} +: 8];
  assign READDATA = rd_hit ? sel_byte : readdata_q;

  // Memory transfer is complete only once busy has been seen and then dropped.
  assign mem_done = seen_busy && !MEM_BUSYWAIT;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req && !hit) state_next = line_dirty && line_valid ? WB : FETCH;
      WB:      if (mem_done) state_next = FETCH;
      FETCH:   if (mem_done) state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    case (state)
      WB: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {line_tag, idx};
        MEM_WRITEDATA = line_data;
      end
      FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {tag_in, idx};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      seen_busy  <= 1'b0;
      readdata_q <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        seen_busy <= 1'b0;
      else if (state == WB || state == FETCH)
        seen_busy <= seen_busy | MEM_BUSYWAIT;
      if (rd_hit)
        readdata_q <= sel_byte;
    end
  end

endmodule

// File: tb/tb_dcache.sv
// tb/tb_dcache.sv - directed self-checking bench for dcache with a busy-memory responder
module tb_dcache;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ, MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA = 32'h0;
  logic        MEM_BUSYWAIT = 1'b0;

  dcache dut (
    .CLOCK         (CLOCK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  always #5 CLOCK = ~CLOCK;

  logic [31:0] mem [64];
  logic [5:0]  wb_addr, fetch_addr;
  logic [31:0] wb_data;
  int          overlap = 0;
  bit          active = 0;
  int          cnt = 0;
  int          total = 0;
  int          passed = 0;
  int          stalls;

  // Memory: busy for 5 sampled edges per transfer, then completes.
  always @(negedge CLOCK) begin
    if (RESET) begin
      active       = 0;
      MEM_BUSYWAIT = 1'b0;
    end else begin
      if (MEM_READ && MEM_WRITE) overlap++;
      if (MEM_READ || MEM_WRITE) begin
        if (!active) begin
          active       = 1;
          cnt          = 5;
          MEM_BUSYWAIT = 1'b1;
          if (MEM_WRITE) begin
            wb_addr = MEM_ADDRESS;
            wb_data = MEM_WRITEDATA;
          end else begin
            fetch_addr = MEM_ADDRESS;
          end
        end else if (cnt > 1) begin
          cnt--;
        end else begin
          MEM_BUSYWAIT = 1'b0;
          active       = 0;
          if (MEM_WRITE) mem[wb_addr] = wb_data;
          else MEM_READDATA = mem[fetch_addr];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_req(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    @(posedge CLOCK); #1;
    READ = r; WRITE = w; ADDRESS = a; WRITEDATA = d;
  endtask

  // Returns at a falling edge where BUSYWAIT is low; stalls counts busy falling edges.
  task automatic wait_done(input string tag, output int n);
    n = 0;
    @(negedge CLOCK);
    while (BUSYWAIT && n < 200) begin
      n++;
      @(negedge CLOCK);
    end
    if (n >= 200) check({tag, "_timeout"}, 32'(n), 32'd0);
  endtask

  task automatic drop_req();
    @(posedge CLOCK); #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'hDDCCBBAA;
    mem[1] = 32'h87654321;
    mem[8] = 32'h44332211;
    mem[9] = 32'h0000AB00;
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;

    #12;
    check("rst_busywait", {31'b0, BUSYWAIT}, 32'd0);
    check("rst_mem_read", {31'b0, MEM_READ}, 32'd0);
    check("rst_mem_write", {31'b0, MEM_WRITE}, 32'd0);
    check("rst_mem_address", {26'b0, MEM_ADDRESS}, 32'd0);
    check("rst_mem_writedata", MEM_WRITEDATA, 32'd0);
    check("rst_readdata", {24'b0, READDATA}, 32'd0);
    @(negedge CLOCK); RESET = 1'b0;

    // Clean miss: 1 IDLE-miss cycle + 6 FETCH + 1 UPDATE stalls.
    set_req(1'b1, 1'b0, 8'h00, 8'h00);
    wait_done("miss00", stalls);
    check("miss00_stalls", 32'(stalls), 32'd8);
    check("miss00_fetch_addr", {26'b0, fetch_addr}, 32'h00);
    check("miss00_readdata", {24'b0, READDATA}, 32'hAA);
    drop_req();

    set_req(1'b1, 1'b0, 8'h03, 8'h00);
    wait_done("hit03", stalls);
    check("hit03_stalls", 32'(stalls), 32'd0);
    check("hit03_readdata", {24'b0, READDATA}, 32'hDD);
    drop_req();

    set_req(1'b0, 1'b1, 8'h01, 8'h5A);
    wait_done("wr01", stalls);
    check("wr01_stalls", 32'(stalls), 32'd0);
    check("wr01_readdata_hold", {24'b0, READDATA}, 32'hDD);
    drop_req();

    set_req(1'b1, 1'b0, 8'h01, 8'h00);
    wait_done("rd01", stalls);
    check("rd01_readdata", {24'b0, READDATA}, 32'h5A);
    drop_req();

    // Dirty miss: 1 + 6 WB + 6 FETCH + 1 UPDATE stalls.
    set_req(1'b1, 1'b0, 8'h21, 8'h00);
    wait_done("miss21", stalls);
    check("miss21_stalls", 32'(stalls), 32'd14);
    check("miss21_wb_addr", {26'b0, wb_addr}, 32'h00);
    check("miss21_wb_data", wb_data, 32'hDDCC5AAA);
    check("miss21_fetch_addr", {26'b0, fetch_addr}, 32'h08);
    check("miss21_readdata", {24'b0, READDATA}, 32'h22);
    drop_req();

    // Reset in the middle of a fetch.
    set_req(1'b1, 1'b0, 8'h00, 8'h00);
    @(negedge CLOCK); @(negedge CLOCK); @(negedge CLOCK);
    check("midrst_fetching", {31'b0, MEM_READ}, 32'd1);
    #2 RESET = 1'b1;
    #1;
    check("midrst_mem_read", {31'b0, MEM_READ}, 32'd0);
    check("midrst_mem_address", {26'b0, MEM_ADDRESS}, 32'd0);
    check("midrst_busywait", {31'b0, BUSYWAIT}, 32'd1);
    @(negedge CLOCK); #2 RESET = 1'b0;
    @(negedge CLOCK);
    check("midrst_rereq_miss", {31'b0, BUSYWAIT}, 32'd1);
    wait_done("midrst_refill", stalls);
    check("midrst_fetch_addr", {26'b0, fetch_addr}, 32'h00);
    check("midrst_readdata", {24'b0, READDATA}, 32'hAA);
    drop_req();

    set_req(1'b1, 1'b0, 8'h04, 8'h00);
    wait_done("miss04", stalls);
    check("miss04_readdata", {24'b0, READDATA}, 32'h21);
    drop_req();

    // READ and WRITE together act as a store.
    set_req(1'b1, 1'b1, 8'h04, 8'h99);
    wait_done("rw04", stalls);
    check("rw04_stalls", 32'(stalls), 32'd0);
    check("rw04_readdata_hold", {24'b0, READDATA}, 32'h21);
    drop_req();

    set_req(1'b1, 1'b0, 8'h04, 8'h00);
    wait_done("rd04", stalls);
    check("rd04_readdata", {24'b0, READDATA}, 32'h99);
    drop_req();

    set_req(1'b1, 1'b0, 8'h25, 8'h00);
    wait_done("miss25", stalls);
    check("miss25_stalls", 32'(stalls), 32'd14);
    check("miss25_wb_addr", {26'b0, wb_addr}, 32'h01);
    check("miss25_wb_data", wb_data, 32'h87654399);
    check("miss25_fetch_addr", {26'b0, fetch_addr}, 32'h09);
    check("miss25_readdata", {24'b0, READDATA}, 32'hAB);
    drop_req();

    check("mem_rw_overlap", 32'(overlap), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
